// File: rtl/ec_pkg.sv
// Shared encodings for the accumulator-processor control unit.
// Holds opcode codes, FSM state encodings (also shown on the debug LEDs)
// and the accumulator source-select codes driven on Asel.
package ec_pkg;

  localparam logic [2:0] OP_LOAD  = 3'b000;
  localparam logic [2:0] OP_STORE = 3'b001;
  localparam logic [2:0] OP_ADD   = 3'b010;
  localparam logic [2:0] OP_SUB   = 3'b011;
  localparam logic [2:0] OP_INPUT = 3'b100;
  localparam logic [2:0] OP_JZ    = 3'b101;
  localparam logic [2:0] OP_JPOS  = 3'b110;
  localparam logic [2:0] OP_HALT  = 3'b111;

  // Encodings are fixed because State is exported for LED debug.
  typedef enum logic [3:0] {
    S_START  = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_LOAD   = 4'd3,
    S_STORE  = 4'd4,
    S_ADD    = 4'd5,
    S_SUB    = 4'd6,
    S_INPUT  = 4'd7,
    S_INWAIT = 4'd8,
    S_JZ     = 4'd9,
    S_JPOS   = 4'd10,
    S_HALT   = 4'd11
  } ec_state_t;

  localparam logic [1:0] ASEL_ALU  = 2'b00;
  localparam logic [1:0] ASEL_IN   = 2'b01;
  localparam logic [1:0] ASEL_MEM  = 2'b10;
  localparam logic [1:0] ASEL_ZERO = 2'b11;

endpackage

// File: rtl/ec_controller.sv
// Control FSM for the 8-bit accumulator processor datapath.
// Inputs : Clock, Resetn (sync, active-low), IR (opcode), Aeq0/Apos (A status),
//          Enter (debounced operator key, level).
// Outputs: datapath control word Reset, IRload, JMPmux, PCload, Meminst, MemWr,
//          Asel[1:0], Aload, Sub; Halt while halted; State[3:0] for LED debug.
// Moore outputs except Aload in INPUT and PCload in JZ/JPOS.
module ec_controller
  import ec_pkg::*;
(
  input  logic       Clock,
  input  logic       Resetn,
  input  logic [2:0] IR,
  input  logic       Aeq0,
  input  logic       Apos,
  input  logic       Enter,
  output logic       Reset,
  output logic       IRload,
  output logic       JMPmux,
  output logic       PCload,
  output logic       Meminst,
  output logic       MemWr,
  output logic [1:0] Asel,
  output logic       Aload,
  output logic       Sub,
  output logic       Halt,
  output logic [3:0] State
);

  ec_state_t state, state_next;

  always_ff @(posedge Clock) begin
    if (!Resetn) state <= S_START;
    else         state <= state_next;
  end

  always_comb begin
    state_next = S_START;
    case (state)
      S_START:  state_next = S_FETCH;
      S_FETCH:  state_next = S_DECODE;
      S_DECODE: begin
        case (IR)
          OP_LOAD:  state_next = S_LOAD;
          OP_STORE: state_next = S_STORE;
          OP_ADD:   state_next = S_ADD;
          OP_SUB:   state_next = S_SUB;
          OP_INPUT: state_next = S_INPUT;
          OP_JZ:    state_next = S_JZ;
          OP_JPOS:  state_next = S_JPOS;
          default:  state_next = S_HALT;
        endcase
      end
      S_LOAD, S_STORE, S_ADD, S_SUB, S_JZ, S_JPOS: state_next = S_FETCH;
      // Enter must be seen high then low so one key press loads exactly once.
      S_INPUT:  state_next = Enter ? S_INWAIT : S_INPUT;
      S_INWAIT: state_next = Enter ? S_INWAIT : S_FETCH;
      S_HALT:   state_next = S_HALT;
      default:  state_next = S_START;
    endcase
  end

  always_comb begin
    Reset   = 1'b0;
    IRload  = 1'b0;
    JMPmux  = 1'b0;
    PCload  = 1'b0;
    Meminst = 1'b0;
    MemWr   = 1'b0;
    Asel    = ASEL_ALU;
    Aload   = 1'b0;
    Sub     = 1'b0;
    Halt    = 1'b0;
    case (state)
      S_START: Reset = 1'b1;
      S_FETCH: begin
        IRload  = 1'b1;
        PCload  = 1'b1;
        Meminst = 1'b1;
      end
      S_LOAD: begin
        Asel  = ASEL_MEM;
        Aload = 1'b1;
      end
      S_STORE: MemWr = 1'b1;
      S_ADD:   Aload = 1'b1;
      S_SUB: begin
        Sub   = 1'b1;
        Aload = 1'b1;
      end
      S_INPUT: begin
        Asel  = ASEL_IN;
        Aload = Enter;
      end
      S_JZ: begin
        JMPmux = 1'b1;
        PCload = Aeq0;
      end
      S_JPOS: begin
        JMPmux = 1'b1;
        PCload = Apos;
      end
      S_HALT:  Halt = 1'b1;
      default: ;
    endcase
  end

  assign State = state;

endmodule

// File: tb/tb_ec_controller.sv
// Directed self-checking bench for ec_controller.
module tb_ec_controller;

  logic       Clock = 1'b0;
  logic       Resetn;
  logic [2:0] IR;
  logic       Aeq0, Apos, Enter;
  logic       Reset, IRload, JMPmux, PCload, Meminst, MemWr, Aload, Sub, Halt;
  logic [1:0] Asel;
  logic [3:0] State;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  ec_controller dut (
    .Clock  (Clock),
    .Resetn (Resetn),
    .IR     (IR),
    .Aeq0   (Aeq0),
    .Apos   (Apos),
    .Enter  (Enter),
    .Reset  (Reset),
    .IRload (IRload),
    .JMPmux (JMPmux),
    .PCload (PCload),
    .Meminst(Meminst),
    .MemWr  (MemWr),
    .Asel   (Asel),
    .Aload  (Aload),
    .Sub    (Sub),
    .Halt   (Halt),
    .State  (State)
  );

  always #5 Clock = ~Clock;

  // Control word order: Reset IRload JMPmux PCload Meminst MemWr Asel[1:0] Aload Sub Halt
  logic [10:0] ctrl;
  assign ctrl = {Reset, IRload, JMPmux, PCload, Meminst, MemWr, Asel, Aload, Sub, Halt};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle; inputs are changed only between steps.
  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  int unsigned aload_count;
  logic [10:0] halt_or;

  initial begin
    Resetn = 1'b0; IR = 3'b000; Aeq0 = 1'b0; Apos = 1'b0; Enter = 1'b0;

    // Reset held for two edges
    step(); step();
    check("rst_state", State, 0);
    check("rst_ctrl", ctrl, 11'b1_0_0_0_0_0_00_0_0_0);
    Resetn = 1'b1;
    step();
    check("fetch_state", State, 1);
    check("fetch_ctrl", ctrl, 11'b0_1_0_1_1_0_00_0_0_0);

    // LOAD then ADD: trace 1,2,3,1,2,5
    IR = 3'b000;
    step(); check("load_dec_state", State, 2);
    check("load_dec_ctrl", ctrl, 0);
    step(); check("load_state", State, 3);
    check("load_ctrl", ctrl, 11'b0_0_0_0_0_0_10_1_0_0);
    IR = 3'b010;
    step(); check("add_fetch_state", State, 1);
    step(); check("add_dec_state", State, 2);
    step(); check("add_state", State, 5);
    check("add_ctrl", ctrl, 11'b0_0_0_0_0_0_00_1_0_0);

    // SUB
    IR = 3'b011;
    step(); step(); step();
    check("sub_state", State, 6);
    check("sub_ctrl", ctrl, 11'b0_0_0_0_0_0_00_1_1_0);

    // STORE: one cycle of MemWr, then FETCH
    IR = 3'b001;
    step(); step(); step();
    check("store_state", State, 4);
    check("store_ctrl", ctrl, 11'b0_0_0_0_0_1_00_0_0_0);
    step();
    check("store_after_state", State, 1);
    check("store_after_memwr", MemWr, 0);

    // INPUT handshake
    IR = 3'b100;
    aload_count = 0;
    step(); step();
    check("input_state", State, 7);
    check("input_ctrl_idle", ctrl, 11'b0_0_0_0_0_0_01_0_0_0);
    for (int i = 0; i < 4; i++) begin
      step();
      if (Aload) aload_count++;
    end
    check("input_waits_state", State, 7);
    Enter = 1'b1; #1;
    check("input_enter_aload", Aload, 1);
    if (Aload) aload_count++;
    for (int i = 0; i < 3; i++) begin
      step();
      if (Aload) aload_count++;
    end
    check("inwait_state", State, 8);
    check("inwait_ctrl", ctrl, 0);
    Enter = 1'b0; #1;
    step();
    check("input_release_fetch", State, 1);
    check("input_aload_once", aload_count, 1);

    // Enter already high on entry: load in first INPUT cycle
    Enter = 1'b1;
    step(); step();
    check("input_early_state", State, 7);
    check("input_early_aload", Aload, 1);
    step();
    check("input_early_inwait", State, 8);
    Enter = 1'b0;
    step();

    // JZ
    IR = 3'b101; Aeq0 = 1'b1;
    step(); step();
    check("jz_state", State, 9);
    check("jz_taken", {JMPmux, PCload}, 2'b11);
    Aeq0 = 1'b0; #1;
    check("jz_not_taken", {JMPmux, PCload}, 2'b10);
    step();
    check("jz_next_fetch", State, 1);

    // JPOS
    IR = 3'b110; Apos = 1'b1;
    step(); step();
    check("jpos_state", State, 10);
    check("jpos_taken", {JMPmux, PCload}, 2'b11);
    Apos = 1'b0; #1;
    check("jpos_not_taken", {JMPmux, PCload}, 2'b10);
    step();

    // HALT: 20 cycles with no control activity despite wiggling inputs
    IR = 3'b111;
    step(); step();
    check("halt_state", State, 11);
    check("halt_ctrl", ctrl, 11'b0_0_0_0_0_0_00_0_0_1);
    halt_or = '0;
    for (int i = 0; i < 20; i++) begin
      Enter = i[0]; Aeq0 = i[1]; Apos = i[2]; IR = i[2:0];
      step();
      halt_or |= ctrl;
    end
    check("halt_stays", State, 11);
    check("halt_no_pulses", halt_or, 11'b0_0_0_0_0_0_00_0_0_1);

    // Reset out of HALT
    Enter = 1'b0; Aeq0 = 1'b0; Apos = 1'b0;
    Resetn = 1'b0;
    step();
    check("halt_reset_state", State, 0);
    check("halt_reset_ctrl", Reset, 1);
    Resetn = 1'b1;

    // Reset mid-INPUT with Enter high: reset wins
    IR = 3'b100;
    step(); step(); step();
    check("rst_input_pre", State, 7);
    Enter = 1'b1; Resetn = 1'b0;
    step();
    check("rst_input_state", State, 0);

    // Reset mid-INWAIT
    Resetn = 1'b1; Enter = 1'b0;
    step(); step(); step();
    Enter = 1'b1;
    step();
    check("rst_inwait_pre", State, 8);
    Resetn = 1'b0;
    step();
    check("rst_inwait_state", State, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
